// File: rtl/peri_pkg.sv
// Shared types and constants for the peripheral responder: FSM encoding,
// register index assignments and the default read-error pattern.
package peri_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ACK,
        S_RD_ACK,
        S_RD_WAIT,
        S_RD_RESP,
        S_CMPL
    } state_e;

    localparam int          REG_CYCLE    = 0;
    localparam int          REG_GPIO     = 1;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/peri_if.sv
// Peripheral bus between the pipeline's initiator (master) and a target (slave).
// Signal names match the core's peripheral bus naming.
interface peri_if;

    logic [31:0] WR_ADDR_TO_PERI;
    logic [31:0] DATA_TO_PERI;
    logic        WR_TO_PERI_VALID;
    logic        WR_TO_PERI_READY;
    logic [31:0] RD_ADDR_TO_PERI;
    logic        RD_ADDR_TO_PERI_VALID;
    logic        RD_ADDR_TO_PERI_READY;
    logic [31:0] DATA_FROM_PERI;
    logic        DATA_FROM_PERI_VALID;
    logic        DATA_FROM_PERI_READY;
    logic        TRANSACTION_COMPLETE_PERI;

    modport master (
        output WR_ADDR_TO_PERI, DATA_TO_PERI, WR_TO_PERI_VALID,
        output RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID, DATA_FROM_PERI_READY,
        input  WR_TO_PERI_READY, RD_ADDR_TO_PERI_READY,
        input  DATA_FROM_PERI, DATA_FROM_PERI_VALID, TRANSACTION_COMPLETE_PERI
    );

    modport slave (
        input  WR_ADDR_TO_PERI, DATA_TO_PERI, WR_TO_PERI_VALID,
        input  RD_ADDR_TO_PERI, RD_ADDR_TO_PERI_VALID, DATA_FROM_PERI_READY,
        output WR_TO_PERI_READY, RD_ADDR_TO_PERI_READY,
        output DATA_FROM_PERI, DATA_FROM_PERI_VALID, TRANSACTION_COMPLETE_PERI
    );

endinterface

// File: rtl/peri_reg_bank.sv
// Register bank behind the responder: address decode, storage, free-running
// cycle counter in reg 0, GPIO mirror of reg 1 and a raw read mux.
module peri_reg_bank
    import peri_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] ADDR_MASK = 32'h0000_00FF,
    parameter int          NUM_REGS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_err,
    output logic [31:0] gpio_out
);

    localparam int IW = $clog2(NUM_REGS);

    function automatic logic addr_ok(logic [31:0] a);
        return ((a & ~ADDR_MASK) == BASE_ADDR) &&
               (a[1:0] == 2'b00) &&
               ((a & ADDR_MASK) < 32'(NUM_REGS * 4));
    endfunction

    logic [31:0]   regs_q [NUM_REGS];
    logic [31:0]   gpio_q;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          wr_ok;

    assign wr_idx = wr_addr[IW+1:2];
    assign rd_idx = rd_addr[IW+1:2];
    assign wr_ok  = addr_ok(wr_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            gpio_q <= '0;
        end else begin
            regs_q[IW'(REG_CYCLE)] <= regs_q[IW'(REG_CYCLE)] + 32'd1;
            // Later assignment wins, so a bus write to reg 0 overrides the increment.
            if (wr_en && wr_ok) regs_q[wr_idx] <= wr_data;
            gpio_q <= regs_q[IW'(REG_GPIO)];
        end
    end

    assign rd_err   = !addr_ok(rd_addr);
    assign rd_data  = regs_q[rd_idx];
    assign gpio_out = gpio_q;

endmodule

// File: rtl/peri_responder.sv
// Target-side peripheral bus responder: one transaction in flight, registered
// handshake outputs, completion pulse per transaction, backed by peri_reg_bank.
module peri_responder
    import peri_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [31:0] ADDR_MASK  = 32'h0000_00FF,
    parameter int          NUM_REGS   = 8,
    parameter int          RD_LATENCY = 0,
    parameter logic [31:0] ERR_DATA   = DEF_ERR_DATA
) (
    input  logic        CLK,
    input  logic        RESET,
    peri_if.slave       bus,
    output logic [31:0] GPIO_OUT
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] data_q, data_d;
    logic        wr_rdy_q, rd_rdy_q, dvld_q, cmpl_q;
    logic [31:0] rd_data;
    logic        rd_err;

    peri_reg_bank #(
        .BASE_ADDR(BASE_ADDR),
        .ADDR_MASK(ADDR_MASK),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (state_q == S_WR_ACK),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_addr (addr_q),
        .rd_data (rd_data),
        .rd_err  (rd_err),
        .gpio_out(GPIO_OUT)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.WR_TO_PERI_VALID) begin
                    addr_d  = bus.WR_ADDR_TO_PERI;
                    wdata_d = bus.DATA_TO_PERI;
                    state_d = S_WR_ACK;
                end else if (bus.RD_ADDR_TO_PERI_VALID) begin
                    addr_d  = bus.RD_ADDR_TO_PERI;
                    state_d = S_RD_ACK;
                end
            end
            S_WR_ACK: state_d = S_CMPL;
            S_RD_ACK: begin
                wcnt_d  = 4'(RD_LATENCY);
                state_d = (RD_LATENCY > 0) ? S_RD_WAIT : S_RD_RESP;
            end
            S_RD_WAIT: begin
                if (wcnt_q == 4'd1) state_d = S_RD_RESP;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_RD_RESP: if (bus.DATA_FROM_PERI_READY) state_d = S_CMPL;
            S_CMPL:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Snapshot read data once on entry so it stays stable while VALID is held.
        if (state_d == S_RD_RESP && state_q != S_RD_RESP)
            data_d = rd_err ? ERR_DATA : rd_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wcnt_q   <= '0;
            data_q   <= '0;
            wr_rdy_q <= 1'b0;
            rd_rdy_q <= 1'b0;
            dvld_q   <= 1'b0;
            cmpl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wcnt_q   <= wcnt_d;
            data_q   <= data_d;
            wr_rdy_q <= (state_d == S_WR_ACK);
            rd_rdy_q <= (state_d == S_RD_ACK);
            dvld_q   <= (state_d == S_RD_RESP);
            cmpl_q   <= (state_d == S_CMPL);
        end
    end

    assign bus.WR_TO_PERI_READY          = wr_rdy_q;
    assign bus.RD_ADDR_TO_PERI_READY     = rd_rdy_q;
    assign bus.DATA_FROM_PERI_VALID      = dvld_q;
    assign bus.DATA_FROM_PERI            = data_q;
    assign bus.TRANSACTION_COMPLETE_PERI = cmpl_q;

endmodule

// File: tb/tb_peri_responder.sv
// Bench for peri_responder: reset checks, a directed vector table, hand-written
// corner sequences and random traffic against a behavioural register model.
module tb_peri_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam int          NREG = 8;
    localparam int          LAT  = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] GPIO_OUT;
    peri_if      bus ();

    peri_responder #(
        .BASE_ADDR (BASE),
        .ADDR_MASK (32'h0000_00FF),
        .NUM_REGS  (NREG),
        .RD_LATENCY(LAT),
        .ERR_DATA  (ERR)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus),
        .GPIO_OUT(GPIO_OUT)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_cmpl = 0;

    // Reference model: scratch/GPIO contents plus a cycle counter that follows
    // "+1 per cycle unless a write to reg 0 commits on that edge".
    logic [31:0] m_regs [NREG];
    logic [31:0] m_cnt;
    logic        m_wr0     = 1'b0;
    logic [31:0] m_wr0_val = '0;
    int          w0_cyc    = 0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (bus.TRANSACTION_COMPLETE_PERI) n_cmpl <= n_cmpl + 1;
        if (RESET)      m_cnt <= '0;
        else if (m_wr0) m_cnt <= m_wr0_val;
        else            m_cnt <= m_cnt + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && (off < NREG * 4) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [31:0] cnt);
        int idx;
        if (!m_ok(a)) return ERR;
        idx = int'((a - BASE) / 4);
        return (idx == 0) ? cnt : m_regs[idx];
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after COMPLETE.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int c0, idx;
        c0  = n_cmpl;
        idx = int'((a - BASE) / 4);
        bus.WR_ADDR_TO_PERI  = a;
        bus.DATA_TO_PERI     = d;
        bus.WR_TO_PERI_VALID = 1'b1;
        @(negedge CLK);
        check("wr_ready_c1", 32'(bus.WR_TO_PERI_READY), 1);
        check("wr_rdready_c1", 32'(bus.RD_ADDR_TO_PERI_READY), 0);
        check("wr_cmpl_c1", 32'(bus.TRANSACTION_COMPLETE_PERI), 0);
        bus.WR_TO_PERI_VALID = 1'b0;
        if (m_ok(a) && idx == 0) begin
            m_wr0     = 1'b1;
            m_wr0_val = d;
            w0_cyc    = cyc + 1;
        end
        @(negedge CLK);
        m_wr0 = 1'b0;
        if (m_ok(a) && idx != 0) m_regs[idx] = d;
        check("wr_ready_c2", 32'(bus.WR_TO_PERI_READY), 0);
        check("wr_cmpl_c2", 32'(bus.TRANSACTION_COMPLETE_PERI), 1);
        @(negedge CLK);
        check("wr_cmpl_c3", 32'(bus.TRANSACTION_COMPLETE_PERI), 0);
        check("gpio", GPIO_OUT, m_regs[1]);
        check("wr_one_cmpl", 32'(n_cmpl - c0), 1);
    endtask

    // Read with READY_in raised after rdly cycles of VALID (0 = held high).
    task automatic do_read(input logic [31:0] a, input int rdly,
                           output logic [31:0] data, output logic [31:0] snap, output int snap_cyc);
        int c0;
        c0 = n_cmpl;
        bus.RD_ADDR_TO_PERI       = a;
        bus.RD_ADDR_TO_PERI_VALID = 1'b1;
        bus.DATA_FROM_PERI_READY  = (rdly == 0);
        @(negedge CLK);
        check("rd_ready_c1", 32'(bus.RD_ADDR_TO_PERI_READY), 1);
        check("rd_wrready_c1", 32'(bus.WR_TO_PERI_READY), 0);
        bus.RD_ADDR_TO_PERI_VALID = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge CLK);
            check("rd_wait_novalid", 32'(bus.DATA_FROM_PERI_VALID), 0);
        end
        snap     = m_cnt;
        snap_cyc = cyc;
        @(negedge CLK);
        check("rd_valid", 32'(bus.DATA_FROM_PERI_VALID), 1);
        check("rd_rdready_low", 32'(bus.RD_ADDR_TO_PERI_READY), 0);
        data = bus.DATA_FROM_PERI;
        for (int k = 0; k < rdly; k++) begin
            @(negedge CLK);
            check("rd_valid_held", 32'(bus.DATA_FROM_PERI_VALID), 1);
            check("rd_data_stable", bus.DATA_FROM_PERI, data);
            check("rd_no_early_cmpl", 32'(bus.TRANSACTION_COMPLETE_PERI), 0);
        end
        bus.DATA_FROM_PERI_READY = 1'b1;
        @(negedge CLK);
        check("rd_valid_drop", 32'(bus.DATA_FROM_PERI_VALID), 0);
        check("rd_cmpl", 32'(bus.TRANSACTION_COMPLETE_PERI), 1);
        bus.DATA_FROM_PERI_READY = 1'b0;
        @(negedge CLK);
        check("rd_cmpl_once", 32'(bus.TRANSACTION_COMPLETE_PERI), 0);
        check("rd_one_cmpl", 32'(n_cmpl - c0), 1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] rd, snap, a;
        int          scyc, c0;

        tbl[0]  = '{1'b1, BASE + 32'h04, 32'h1234_5678, 32'h0};
        tbl[1]  = '{1'b1, BASE + 32'h08, 32'hA5A5_0001, 32'h0};
        tbl[2]  = '{1'b0, BASE + 32'h08, 32'h0,         32'hA5A5_0001};
        tbl[3]  = '{1'b0, BASE + 32'h40, 32'h0,         ERR};
        tbl[4]  = '{1'b0, BASE + 32'h02, 32'h0,         ERR};
        tbl[5]  = '{1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{1'b0, BASE + 32'h04, 32'h0,         32'h1234_5678};
        tbl[7]  = '{1'b1, BASE + 32'h1C, 32'hCAFE_0007, 32'h0};
        tbl[8]  = '{1'b0, BASE + 32'h1C, 32'h0,         32'hCAFE_0007};
        tbl[9]  = '{1'b0, 32'h8000_0100, 32'h0,         ERR};
        tbl[10] = '{1'b1, BASE + 32'h0D, 32'h0000_0001, 32'h0};
        tbl[11] = '{1'b0, BASE + 32'h0C, 32'h0,         32'h0};

        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        bus.WR_ADDR_TO_PERI       = '0;
        bus.DATA_TO_PERI          = '0;
        bus.WR_TO_PERI_VALID      = 1'b0;
        bus.RD_ADDR_TO_PERI       = '0;
        bus.RD_ADDR_TO_PERI_VALID = 1'b0;
        bus.DATA_FROM_PERI_READY  = 1'b0;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_wr_ready", 32'(bus.WR_TO_PERI_READY), 0);
        check("rst_rd_ready", 32'(bus.RD_ADDR_TO_PERI_READY), 0);
        check("rst_valid", 32'(bus.DATA_FROM_PERI_VALID), 0);
        check("rst_data", bus.DATA_FROM_PERI, 0);
        check("rst_cmpl", 32'(bus.TRANSACTION_COMPLETE_PERI), 0);
        check("rst_gpio", GPIO_OUT, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Directed table: GPIO write, latency-3 read, bad decode, ignored writes.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data);
            else begin
                do_read(tbl[i].addr, i % 3, rd, snap, scyc);
                check($sformatf("tbl%0d", i), rd, tbl[i].exp);
            end
        end

        // Counter load near the top, then read it back after it has wrapped.
        do_write(BASE, 32'hFFFF_FFFE);
        do_read(BASE, 0, rd, snap, scyc);
        check("cnt_wrap", rd, 32'hFFFF_FFFE + 32'(scyc - w0_cyc));
        check("cnt_model", rd, snap);

        // Write and read valid together: write first, read after its completion.
        c0 = n_cmpl;
        bus.WR_ADDR_TO_PERI       = BASE + 32'h10;
        bus.DATA_TO_PERI          = 32'h0BAD_F00D;
        bus.WR_TO_PERI_VALID      = 1'b1;
        bus.RD_ADDR_TO_PERI       = BASE + 32'h10;
        bus.RD_ADDR_TO_PERI_VALID = 1'b1;
        bus.DATA_FROM_PERI_READY  = 1'b1;
        @(negedge CLK);
        check("both_wr_ready", 32'(bus.WR_TO_PERI_READY), 1);
        check("both_rd_wait1", 32'(bus.RD_ADDR_TO_PERI_READY), 0);
        bus.WR_TO_PERI_VALID = 1'b0;
        @(negedge CLK);
        m_regs[4] = 32'h0BAD_F00D;
        check("both_wr_cmpl", 32'(bus.TRANSACTION_COMPLETE_PERI), 1);
        check("both_rd_wait2", 32'(bus.RD_ADDR_TO_PERI_READY), 0);
        @(negedge CLK);
        check("both_rd_wait3", 32'(bus.RD_ADDR_TO_PERI_READY), 0);
        @(negedge CLK);
        check("both_rd_ready", 32'(bus.RD_ADDR_TO_PERI_READY), 1);
        bus.RD_ADDR_TO_PERI_VALID = 1'b0;
        repeat (LAT + 1) @(negedge CLK);
        check("both_rd_valid", 32'(bus.DATA_FROM_PERI_VALID), 1);
        check("both_rd_data", bus.DATA_FROM_PERI, 32'h0BAD_F00D);
        @(negedge CLK);
        check("both_rd_cmpl", 32'(bus.TRANSACTION_COMPLETE_PERI), 1);
        bus.DATA_FROM_PERI_READY = 1'b0;
        @(negedge CLK);
        check("both_two_cmpl", 32'(n_cmpl - c0), 2);

        // Reset while read data is waiting for READY.
        do_write(BASE + 32'h04, 32'h0000_0055);
        bus.RD_ADDR_TO_PERI       = BASE + 32'h04;
        bus.RD_ADDR_TO_PERI_VALID = 1'b1;
        @(negedge CLK);
        bus.RD_ADDR_TO_PERI_VALID = 1'b0;
        repeat (LAT + 1) @(negedge CLK);
        check("rst_mid_valid", 32'(bus.DATA_FROM_PERI_VALID), 1);
        c0 = n_cmpl;
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        check("rst_mid_valid0", 32'(bus.DATA_FROM_PERI_VALID), 0);
        check("rst_mid_data0", bus.DATA_FROM_PERI, 0);
        check("rst_mid_gpio0", GPIO_OUT, 0);
        repeat (4) @(negedge CLK);
        check("rst_mid_no_cmpl", 32'(n_cmpl - c0), 0);
        do_read(BASE + 32'h04, 1, rd, snap, scyc);
        check("rst_fresh_read", rd, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0, 1, 2, 3: a = BASE + 32'(4 * $urandom_range(0, NREG - 1));
                4:          a = BASE + 32'h40 + 32'(4 * $urandom_range(0, 15));
                5:          a = BASE + 32'(4 * $urandom_range(0, NREG - 1)) + 32'($urandom_range(1, 3));
                default:    a = 32'h9000_0000 + 32'(4 * $urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
            else begin
                do_read(a, $urandom_range(0, 3), rd, snap, scyc);
                check("rand_read", rd, m_read(a, snap));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
